// File: rtl/commit_stage_n.sv
// commit_stage_n: N-lane in-order writeback/commit stage.
// Registers one issue bundle per cycle. Resolves exception/ERET precedence
// inside the bundle, drives the GPR write ports, selects one fetch redirect
// and owns the CP0 Count/Compare timer plus the Cause.IP vector.
//
// Ports:
//   clk, resetn (sync, active-low), stall (hold stage register)
//   in_* : per-lane bundle from the memory stage (flattened, lane 0 oldest)
//   epc, ext_int : ERET target and external interrupt lines
//   rf_wen/rf_dst/rf_data : GPR write ports, one per lane
//   redirect_valid/redirect_target : fetch redirect
//   exc_valid/exc_pc/exc_code, eret_commit, mtc0_commit : commit events
//   count, compare, cause_ip : CP0 timer state and Cause.IP[7:0]
//
// Build option: define COMMIT_TIMER_INT_EN to enable the timer interrupt
// (TI). Without it TI is tied to 0 and cause_ip[7] follows ext_int[5].
module commit_stage_n #(
   parameter int          LANES      = 2,
   parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                stall,
   input  logic [LANES-1:0]    in_valid,
   input  logic [LANES*32-1:0] in_pc,
   input  logic [LANES-1:0]    in_wen,
   input  logic [LANES*5-1:0]  in_dst,
   input  logic [LANES*32-1:0] in_value,
   input  logic [LANES-1:0]    in_exc,
   input  logic [LANES*5-1:0]  in_exc_code,
   input  logic [LANES-1:0]    in_eret,
   input  logic [LANES-1:0]    in_mtc0,
   input  logic [LANES*5-1:0]  in_cp0_dst,
   input  logic [LANES-1:0]    in_jmp,
   input  logic [LANES*32-1:0] in_jmp_target,
   input  logic [31:0]         epc,
   input  logic [5:0]          ext_int,
   output logic [LANES-1:0]    rf_wen,
   output logic [LANES*5-1:0]  rf_dst,
   output logic [LANES*32-1:0] rf_data,
   output logic                redirect_valid,
   output logic [31:0]         redirect_target,
   output logic                exc_valid,
   output logic [31:0]         exc_pc,
   output logic [4:0]          exc_code,
   output logic                eret_commit,
   output logic                mtc0_commit,
   output logic [31:0]         count,
   output logic [31:0]         compare,
   output logic [7:0]          cause_ip
);

   localparam logic [4:0] CP0_COUNT   = 5'd9;
   localparam logic [4:0] CP0_COMPARE = 5'd11;

   logic [LANES-1:0]    vld_q;
   logic [LANES-1:0]    wen_q;
   logic [LANES-1:0]    exc_q;
   logic [LANES-1:0]    eret_q;
   logic [LANES-1:0]    mtc0_q;
   logic [LANES-1:0]    jmp_q;
   logic [LANES*32-1:0] pc_q;
   logic [LANES*32-1:0] value_q;
   logic [LANES*32-1:0] tgt_q;
   logic [LANES*5-1:0]  dst_q;
   logic [LANES*5-1:0]  code_q;
   logic [LANES*5-1:0]  cp0_q;

   // Only the valids need reset; payload is qualified by them.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         vld_q <= '0;
      end else if (!stall) begin
         vld_q <= in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (!stall) begin
         wen_q   <= in_wen;
         exc_q   <= in_exc;
         eret_q  <= in_eret;
         mtc0_q  <= in_mtc0;
         jmp_q   <= in_jmp;
         pc_q    <= in_pc;
         value_q <= in_value;
         tgt_q   <= in_jmp_target;
         dst_q   <= in_dst;
         code_q  <= in_exc_code;
         cp0_q   <= in_cp0_dst;
      end
   end

   logic [LANES-1:0] commit;
   logic             term_hit;
   logic             term_exc;
   logic [31:0]      term_pc;
   logic [4:0]       term_code;
   logic             jmp_hit;
   logic [31:0]      jmp_tgt;

   // Walk lanes oldest first; the first exc/ERET lane commits and closes
   // the bundle so every younger lane is squashed.
   always_comb begin
      commit    = '0;
      term_hit  = 1'b0;
      term_exc  = 1'b0;
      term_pc   = '0;
      term_code = '0;
      jmp_hit   = 1'b0;
      jmp_tgt   = '0;
      for (int i = 0; i < LANES; i++) begin
         if (vld_q[i] && !term_hit) begin
            commit[i] = 1'b1;
            if (jmp_q[i] && !jmp_hit) begin
               jmp_hit = 1'b1;
               jmp_tgt = tgt_q[i*32 +: 32];
            end
            if (exc_q[i] || eret_q[i]) begin
               term_hit  = 1'b1;
               term_exc  = exc_q[i];
               term_pc   = pc_q[i*32 +: 32];
               term_code = code_q[i*5 +: 5];
            end
         end
      end
   end

   always_comb begin
      rf_wen = '0;
      for (int i = 0; i < LANES; i++) begin
         rf_wen[i] = commit[i] & wen_q[i]
                   & (dst_q[i*5 +: 5] != 5'd0)
                   & ~exc_q[i] & ~eret_q[i] & ~mtc0_q[i];
      end
   end

   assign rf_dst  = dst_q;
   assign rf_data = value_q;

   // An exception beats an ERET in the same lane.
   always_comb begin
      redirect_valid  = term_hit | jmp_hit;
      redirect_target = jmp_tgt;
      if (term_hit) begin
         redirect_target = term_exc ? EXC_VECTOR : epc;
      end
   end

   assign exc_valid   = term_hit & term_exc;
   assign exc_pc      = term_pc;
   assign exc_code    = term_code;
   assign eret_commit = term_hit & ~term_exc;
   assign mtc0_commit = |(commit & mtc0_q);

   logic        wr_count;
   logic        wr_cmp;
   logic [31:0] wr_count_val;
   logic [31:0] wr_cmp_val;

   // A held bundle re-presents its MTC0 every stalled cycle; the timer
   // takes the write only in the cycle the bundle actually retires, so a
   // stalled Count write does not freeze the counter. Younger lanes are
   // visited last and therefore win on a shared target register.
   always_comb begin
      wr_count     = 1'b0;
      wr_cmp       = 1'b0;
      wr_count_val = '0;
      wr_cmp_val   = '0;
      for (int i = 0; i < LANES; i++) begin
         if (commit[i] && mtc0_q[i] && !stall) begin
            if (cp0_q[i*5 +: 5] == CP0_COUNT) begin
               wr_count     = 1'b1;
               wr_count_val = value_q[i*32 +: 32];
            end
            if (cp0_q[i*5 +: 5] == CP0_COMPARE) begin
               wr_cmp     = 1'b1;
               wr_cmp_val = value_q[i*32 +: 32];
            end
         end
      end
   end

   logic [31:0] count_q;
   logic [31:0] compare_q;
   logic        ti;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         count_q   <= '0;
         compare_q <= '0;
      end else begin
         count_q <= wr_count ? wr_count_val : count_q + 32'd1;
         if (wr_cmp) begin
            compare_q <= wr_cmp_val;
         end
      end
   end

`ifdef COMMIT_TIMER_INT_EN
   logic ti_q;

   // Match uses the pre-update count, so TI rises together with the
   // Count value that equals Compare. A Compare write always clears it.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ti_q <= 1'b0;
      end else if (wr_cmp) begin
         ti_q <= 1'b0;
      end else if (count_q + 32'd1 == compare_q) begin
         ti_q <= 1'b1;
      end
   end

   assign ti = ti_q;
`else
   assign ti = 1'b0;
`endif

   assign count    = count_q;
   assign compare  = compare_q;
   assign cause_ip = {ext_int[5] | ti, ext_int[4:0], 2'b00};

endmodule

// File: tb/tb_commit_stage_n.sv
// tb_commit_stage_n: self-checking bench for commit_stage_n (LANES=2).
// Table vectors, hand-written timer/stall/reset sequences, random bundles.
`timescale 1ns/1ps
module tb_commit_stage_n;

   localparam int          L    = 2;
   localparam logic [31:0] EXCV = 32'hBFC00380;
`ifdef COMMIT_TIMER_INT_EN
   localparam bit TI_EN = 1'b1;
`else
   localparam bit TI_EN = 1'b0;
`endif

   typedef struct {
      logic        v;
      logic [31:0] pc;
      logic        w;
      logic [4:0]  dst;
      logic [31:0] val;
      logic        x;
      logic [4:0]  code;
      logic        e;
      logic        m;
      logic [4:0]  cd;
      logic        j;
      logic [31:0] tgt;
   } lane_t;

   typedef struct {
      lane_t       l0;
      lane_t       l1;
      logic [31:0] epc;
      logic [1:0]  x_wen;
      logic        x_rv;
      logic [31:0] x_tgt;
      logic        x_exc;
      logic        x_eret;
   } vec_t;

   logic          clk = 1'b0;
   logic          resetn, stall;
   logic [L-1:0]  in_valid, in_wen, in_exc, in_eret, in_mtc0, in_jmp;
   logic [L*32-1:0] in_pc, in_value, in_jmp_target;
   logic [L*5-1:0]  in_dst, in_exc_code, in_cp0_dst;
   logic [31:0]   epc;
   logic [5:0]    ext_int;
   logic [L-1:0]  rf_wen;
   logic [L*5-1:0]  rf_dst;
   logic [L*32-1:0] rf_data;
   logic          redirect_valid, exc_valid, eret_commit, mtc0_commit;
   logic [31:0]   redirect_target, exc_pc, count, compare;
   logic [4:0]    exc_code;
   logic [7:0]    cause_ip;

   commit_stage_n #(.LANES(L), .EXC_VECTOR(EXCV)) dut (
      .clk(clk), .resetn(resetn), .stall(stall),
      .in_valid(in_valid), .in_pc(in_pc), .in_wen(in_wen),
      .in_dst(in_dst), .in_value(in_value), .in_exc(in_exc),
      .in_exc_code(in_exc_code), .in_eret(in_eret),
      .in_mtc0(in_mtc0), .in_cp0_dst(in_cp0_dst), .in_jmp(in_jmp),
      .in_jmp_target(in_jmp_target), .epc(epc), .ext_int(ext_int),
      .rf_wen(rf_wen), .rf_dst(rf_dst), .rf_data(rf_data),
      .redirect_valid(redirect_valid),
      .redirect_target(redirect_target),
      .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_code(exc_code),
      .eret_commit(eret_commit), .mtc0_commit(mtc0_commit),
      .count(count), .compare(compare), .cause_ip(cause_ip)
   );

   always #5 clk = ~clk;

   int ncmp = 0;
   int nbad = 0;

   lane_t       cur[L];
   logic [31:0] cur_epc = '0;
   logic [5:0]  cur_ext = '0;

   lane_t       mq[L];
   logic [31:0] mcount, mcmp;
   logic        mti;

   vec_t tbl[5];

   task automatic chk(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
      ncmp++;
      if (a !== e) begin
         nbad++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask

   function automatic lane_t mk(input logic v, input logic [31:0] pc,
         input logic w, input logic [4:0] dst, input logic [31:0] val,
         input logic x, input logic [4:0] code, input logic e,
         input logic m, input logic [4:0] cd, input logic j,
         input logic [31:0] tgt);
      lane_t r;
      r.v = v; r.pc = pc; r.w = w; r.dst = dst; r.val = val;
      r.x = x; r.code = code; r.e = e; r.m = m; r.cd = cd;
      r.j = j; r.tgt = tgt;
      return r;
   endfunction

   function automatic lane_t nop();
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   function automatic lane_t rnd_lane();
      lane_t r;
      int    sel;
      r.v    = ($urandom % 8) != 0;
      r.pc   = {$urandom, 2'b00} ;
      r.w    = $urandom % 2;
      r.dst  = 5'($urandom % 32);
      r.val  = $urandom;
      r.x    = ($urandom % 7) == 0;
      r.code = 5'($urandom % 32);
      r.e    = ($urandom % 10) == 0;
      r.m    = ($urandom % 6) == 0;
      sel    = $urandom % 3;
      r.cd   = (sel == 0) ? 5'd9 : (sel == 1) ? 5'd11 : 5'd12;
      if (r.m && r.cd == 5'd11) r.val = mcount + $urandom_range(0, 6);
      r.j    = ($urandom % 4) == 0;
      r.tgt  = {$urandom, 2'b00};
      return r;
   endfunction

   // Index of the oldest exc/ERET lane in the held bundle, L if none.
   function automatic int term_lane();
      int t = L;
      for (int i = L - 1; i >= 0; i--)
         if (mq[i].v && (mq[i].x || mq[i].e)) t = i;
      return t;
   endfunction

   task automatic model_outs(output logic [L-1:0] wen, output logic rv,
         output logic [31:0] rt, output logic xv,
         output logic [31:0] xpc, output logic [4:0] xc,
         output logic er, output logic mc);
      int t;
      t = term_lane();
      wen = '0; rv = 0; rt = '0; xv = 0; xpc = '0; xc = '0;
      er = 0; mc = 0;
      for (int i = 0; i < L; i++) begin
         if (mq[i].v && i <= t) begin
            wen[i] = mq[i].w && mq[i].dst != 0 && !mq[i].x
                     && !mq[i].e && !mq[i].m;
            mc = mc | mq[i].m;
         end
      end
      if (t < L) begin
         rv = 1;
         if (mq[t].x) begin
            rt = EXCV; xv = 1; xpc = mq[t].pc; xc = mq[t].code;
         end else begin
            rt = cur_epc; er = 1;
         end
      end else begin
         for (int i = L - 1; i >= 0; i--)
            if (mq[i].v && mq[i].j) begin
               rv = 1; rt = mq[i].tgt;
            end
      end
   endtask

   task automatic model_edge(input logic st, input logic rst);
      int          t;
      logic        wc, wp;
      logic [31:0] wcv, wpv;
      if (!rst) begin
         for (int i = 0; i < L; i++) mq[i].v = 0;
         mcount = 0; mcmp = 0; mti = 0;
      end else begin
         t = term_lane();
         wc = 0; wp = 0; wcv = 0; wpv = 0;
         if (!st)
            for (int i = 0; i < L; i++)
               if (mq[i].v && i <= t && mq[i].m) begin
                  if (mq[i].cd == 5'd9)  begin wc = 1; wcv = mq[i].val; end
                  if (mq[i].cd == 5'd11) begin wp = 1; wpv = mq[i].val; end
               end
         if (mcount + 32'd1 == mcmp) mti = 1;
         if (wp) mti = 0;
         mcount = wc ? wcv : mcount + 32'd1;
         if (wp) mcmp = wpv;
         if (!st) mq = cur;
      end
   endtask

   task automatic drive();
      for (int i = 0; i < L; i++) begin
         in_valid[i]          = cur[i].v;
         in_pc[i*32 +: 32]    = cur[i].pc;
         in_wen[i]            = cur[i].w;
         in_dst[i*5 +: 5]     = cur[i].dst;
         in_value[i*32 +: 32] = cur[i].val;
         in_exc[i]            = cur[i].x;
         in_exc_code[i*5 +: 5] = cur[i].code;
         in_eret[i]           = cur[i].e;
         in_mtc0[i]           = cur[i].m;
         in_cp0_dst[i*5 +: 5] = cur[i].cd;
         in_jmp[i]            = cur[i].j;
         in_jmp_target[i*32 +: 32] = cur[i].tgt;
      end
      epc     = cur_epc;
      ext_int = cur_ext;
   endtask

   task automatic check_all();
      logic [L-1:0] ew;
      logic         erv, exv, eer, emc;
      logic [31:0]  ert, expc;
      logic [4:0]   exc;
      model_outs(ew, erv, ert, exv, expc, exc, eer, emc);
      chk("rf_wen", 32'(rf_wen), 32'(ew));
      for (int i = 0; i < L; i++)
         if (ew[i]) begin
            chk("rf_dst", 32'(rf_dst[i*5 +: 5]), 32'(mq[i].dst));
            chk("rf_data", rf_data[i*32 +: 32], mq[i].val);
         end
      chk("redirect_valid", 32'(redirect_valid), 32'(erv));
      if (erv) chk("redirect_target", redirect_target, ert);
      chk("exc_valid", 32'(exc_valid), 32'(exv));
      if (exv) begin
         chk("exc_pc", exc_pc, expc);
         chk("exc_code", 32'(exc_code), 32'(exc));
      end
      chk("eret_commit", 32'(eret_commit), 32'(eer));
      chk("mtc0_commit", 32'(mtc0_commit), 32'(emc));
      chk("count", count, mcount);
      chk("compare", compare, mcmp);
      chk("cause_ip", 32'(cause_ip),
          {24'b0, cur_ext[5] | (TI_EN & mti), cur_ext[4:0], 2'b00});
   endtask

   task automatic step(input logic st, input logic rst);
      drive();
      stall  = st;
      resetn = rst;
      @(posedge clk);
      model_edge(st, rst);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle_lanes();
      for (int i = 0; i < L; i++) cur[i] = nop();
   endtask

   initial begin
      logic [31:0] c0;

      tbl[0].l0 = mk(1, 32'h80000000, 1, 3, 32'h11, 0, 0, 0, 0, 0, 0, 0);
      tbl[0].l1 = mk(1, 32'h80000004, 1, 4, 32'h22, 0, 0, 0, 0, 0, 0, 0);
      tbl[0].epc = 0; tbl[0].x_wen = 2'b11; tbl[0].x_rv = 0;
      tbl[0].x_tgt = 0; tbl[0].x_exc = 0; tbl[0].x_eret = 0;

      tbl[1].l0 = mk(1, 32'hBFC00100, 0, 0, 0, 1, 5'h04, 0, 0, 0, 0, 0);
      tbl[1].l1 = mk(1, 32'hBFC00104, 1, 5, 32'h55, 0, 0, 0, 0, 0, 0, 0);
      tbl[1].epc = 0; tbl[1].x_wen = 2'b00; tbl[1].x_rv = 1;
      tbl[1].x_tgt = 32'hBFC00380; tbl[1].x_exc = 1; tbl[1].x_eret = 0;

      tbl[2].l0 = mk(1, 32'h80000100, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                     32'h80001000);
      tbl[2].l1 = mk(1, 32'h80000104, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[2].epc = 32'h80002000; tbl[2].x_wen = 2'b00; tbl[2].x_rv = 1;
      tbl[2].x_tgt = 32'h80002000; tbl[2].x_exc = 0; tbl[2].x_eret = 1;

      tbl[3].l0 = mk(1, 32'h80000200, 1, 0, 32'h99, 0, 0, 0, 0, 0, 0, 0);
      tbl[3].l1 = mk(1, 32'h80000204, 1, 7, 32'h77, 0, 0, 0, 0, 0, 1,
                     32'h80003000);
      tbl[3].epc = 0; tbl[3].x_wen = 2'b10; tbl[3].x_rv = 1;
      tbl[3].x_tgt = 32'h80003000; tbl[3].x_exc = 0; tbl[3].x_eret = 0;

      tbl[4].l0 = mk(1, 32'h80000300, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[4].l1 = mk(1, 32'h80000304, 1, 8, 32'h88, 1, 5'h0A, 0, 0, 0, 0, 0);
      tbl[4].epc = 32'h80004000; tbl[4].x_wen = 2'b00; tbl[4].x_rv = 1;
      tbl[4].x_tgt = 32'h80004000; tbl[4].x_exc = 0; tbl[4].x_eret = 1;

      idle_lanes();
      step(0, 0);
      step(0, 0);
      chk("reset_rf_wen", 32'(rf_wen), 0);
      chk("reset_redirect", 32'(redirect_valid), 0);
      chk("reset_count", count, 0);
      chk("reset_compare", compare, 0);

      for (int k = 0; k < 5; k++) begin
         cur[0] = tbl[k].l0;
         cur[1] = tbl[k].l1;
         cur_epc = tbl[k].epc;
         step(0, 1);
         chk("tbl_wen", 32'(rf_wen), 32'(tbl[k].x_wen));
         chk("tbl_rv", 32'(redirect_valid), 32'(tbl[k].x_rv));
         if (tbl[k].x_rv) chk("tbl_tgt", redirect_target, tbl[k].x_tgt);
         chk("tbl_exc", 32'(exc_valid), 32'(tbl[k].x_exc));
         chk("tbl_eret", 32'(eret_commit), 32'(tbl[k].x_eret));
         if (k == 1) chk("tbl_exc_pc", exc_pc, 32'hBFC00100);
      end

      // Two lanes write Count; the younger value wins.
      cur[0] = mk(1, 0, 0, 0, 7, 0, 0, 0, 1, 9, 0, 0);
      cur[1] = mk(1, 4, 0, 0, 9, 0, 0, 0, 1, 9, 0, 0);
      cur_epc = 0;
      step(0, 1);
      idle_lanes();
      step(0, 1);
      chk("count_mtc0", count, 9);
      step(0, 1);
      chk("count_after", count, 10);

      // Count=0, Compare=10, then let it run up to the match.
      cur_ext = 0;
      cur[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
      cur[1] = mk(1, 4, 0, 0, 10, 0, 0, 0, 1, 11, 0, 0);
      step(0, 1);
      idle_lanes();
      for (int k = 0; k < 14; k++) begin
         step(0, 1);
         if (mcount == 9) chk("ti_before", 32'(cause_ip[7]), 0);
         if (mcount == 10) chk("ti_at_match", 32'(cause_ip[7]), 32'(TI_EN));
      end
      chk("ti_sticky", 32'(cause_ip[7]), 32'(TI_EN));
      cur[0] = mk(1, 0, 0, 0, 50, 0, 0, 0, 1, 11, 0, 0);
      step(0, 1);
      idle_lanes();
      step(0, 1);
      chk("ti_cleared", 32'(cause_ip[7]), 0);
      chk("compare_50", compare, 50);

      // Stall holds the bundle while new inputs change; timer keeps going.
      cur[0] = tbl[0].l0;
      cur[1] = tbl[0].l1;
      step(0, 1);
      c0 = mcount;
      for (int k = 0; k < 3; k++) begin
         cur[0] = rnd_lane();
         cur[1] = rnd_lane();
         step(1, 1);
         chk("stall_wen", 32'(rf_wen), 32'h3);
         chk("stall_d0", rf_data[31:0], 32'h11);
         chk("stall_d1", rf_data[63:32], 32'h22);
      end
      chk("stall_count", count, c0 + 32'd3);

      // Reset with a bundle in flight: nothing written afterwards.
      cur[0] = tbl[0].l0;
      cur[1] = tbl[0].l1;
      step(0, 0);
      chk("rst_wen", 32'(rf_wen), 0);
      chk("rst_count", count, 0);
      idle_lanes();
      step(0, 1);
      chk("rst_after_wen", 32'(rf_wen), 0);

      for (int k = 0; k < 400; k++) begin
         cur[0] = rnd_lane();
         cur[1] = rnd_lane();
         cur_epc = {$urandom, 2'b00};
         cur_ext = 6'($urandom);
         step(($urandom % 5) == 0, ($urandom % 97) != 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end

endmodule
